updi_rx_frame: RTL

Receive-side frame decoder for the UPDI single-wire link. It samples the line asynchronously and recovers 12-bit UPDI frames: start (0), 8 data bits LSB-first, even parity, and 2 stop bits (1). It checks parity, stop bits and BREAK, then presents each good byte on a one-entry valid/ready holding register to the response parser. It is the counterpart of the command-generator/transmit path, which builds frames in the same format.

---
 rtl/updi_pkg.sv | 28 ++
 rtl/updi_bit_timer.sv | 35 +++
 rtl/updi_rx_frame.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/updi_pkg.sv
// UPDI shared types and constants.
// Frame format helpers used by the rx and tx paths.
package updi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2,
    BREAK
  } rx_state_e;

  localparam int UPDI_DATA_BITS  = 8;
  localparam int UPDI_FRAME_BITS = 12;
  localparam int UPDI_STOP_BITS  = 2;

  localparam logic [7:0] UPDI_SYNCH_CHAR = 8'h55;

  // Even parity bit for a data byte.
  function automatic logic updi_parity(
    input logic [UPDI_DATA_BITS-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/updi_bit_timer.sv
// UPDI bit timer.
// Strobes at mid-bit, counting from the last restart.
module updi_bit_timer #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic restart,
  output logic strobe
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
  localparam logic [W-1:0] MID  = W'(CLK_DIV / 2 - 1);

  logic [W-1:0] cnt_q;

  // Free-running bit counter, parked at 0 when idle or restarted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (restart || !run) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Restart lands on a falling edge, so half a bit later is mid-bit.
  assign strobe = run && !restart && (cnt_q == MID);

endmodule

// File: rtl/updi_rx_frame.sv
// UPDI receive frame decoder.
// Recovers 8E2 frames, flags errors and BREAK, holds one byte.
module updi_rx_frame
  import updi_pkg::*;
#(
  parameter int CLK_DIV     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_rx_en,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_break,
  output logic       o_overrun,
  output logic       o_busy
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic                   rx_q;
  logic                   fall;

  rx_state_e state_q;
  rx_state_e state_d;

  logic [UPDI_DATA_BITS-1:0] shift_q;
  logic [2:0]                bit_cnt_q;
  logic                      par_q;
  logic                      stop1_q;
  logic                      quiet_q;

  logic strobe;
  logic run;
  logic restart;
  logic shift_en;
  logic par_cap;
  logic stop1_cap;
  logic quiet_set;
  logic quiet_clr;
  logic good;
  logic perr;
  logic ferr;
  logic brk;
  logic accept;
  logic load;
  logic ovr;

  // Line synchroniser plus one flop for edge detect; idles high.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync_q <= '1;
      rx_q   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx};
      rx_q   <= rx_s;
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];
  assign fall = rx_q && !rx_s;
  assign run  = (state_q != IDLE);

  updi_bit_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk     (i_clk),
    .rst_n   (i_rst),
    .run     (run),
    .restart (restart),
    .strobe  (strobe)
  );

  // Frame sequencing and end-of-frame verdict.
  always_comb begin
    state_d   = state_q;
    restart   = 1'b0;
    shift_en  = 1'b0;
    par_cap   = 1'b0;
    stop1_cap = 1'b0;
    quiet_set = 1'b0;
    quiet_clr = 1'b0;
    good      = 1'b0;
    perr      = 1'b0;
    ferr      = 1'b0;
    brk       = 1'b0;
    if (state_q != IDLE && !i_rx_en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_rx_en && fall) begin
            state_d = START;
            restart = 1'b1;
          end
        end
        START: begin
          if (strobe) begin
            state_d = rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (strobe) begin
            shift_en = 1'b1;
            if (bit_cnt_q == 3'd7) begin
              state_d = PARITY;
            end
          end
        end
        PARITY: begin
          if (strobe) begin
            par_cap = 1'b1;
            state_d = STOP1;
          end
        end
        STOP1: begin
          if (strobe) begin
            stop1_cap = 1'b1;
            if (!rx_s && shift_q == '0 && !par_q) begin
              state_d   = BREAK;
              quiet_clr = 1'b1;
            end else begin
              state_d = STOP2;
            end
          end
        end
        STOP2: begin
          if (strobe) begin
            state_d = IDLE;
            if (!stop1_q || !rx_s) begin
              ferr = 1'b1;
              if (!rx_s) begin
                state_d   = BREAK;
                quiet_set = 1'b1;
              end
            end else if (par_q != updi_parity(shift_q)) begin
              perr = 1'b1;
            end else begin
              good = 1'b1;
            end
          end
        end
        BREAK: begin
          if (rx_s) begin
            brk     = !quiet_q;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register and bit capture.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
      stop1_q   <= 1'b0;
      quiet_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (restart) begin
        bit_cnt_q <= '0;
      end else if (shift_en) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
      if (shift_en) begin
        shift_q <= {rx_s, shift_q[UPDI_DATA_BITS-1:1]};
      end
      if (par_cap) begin
        par_q <= rx_s;
      end
      if (stop1_cap) begin
        stop1_q <= rx_s;
      end
      if (quiet_clr) begin
        quiet_q <= 1'b0;
      end else if (quiet_set) begin
        quiet_q <= 1'b1;
      end
    end
  end

  assign accept = o_valid && i_ready;
  assign load   = good && (!o_valid || i_ready);
  assign ovr    = good && o_valid && !i_ready;

  // One-entry holding register and one-cycle status pulses.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_data       <= 8'h00;
      o_valid      <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      if (load) begin
        o_data <= shift_q;
      end
      o_valid      <= load || (o_valid && !accept);
      o_parity_err <= perr;
      o_frame_err  <= ferr;
      o_break      <= brk;
      o_overrun    <= ovr;
    end
  end

  assign o_busy = (state_q != IDLE);

endmodule
